// File: rtl/glitch_fault_monitor.sv
// glitch_fault_monitor
// Checks the glitched adder pipeline result against a golden a+b computed on the
// clean clock. Each trial waits for the pipeline to settle, then samples dut_out on
// two consecutive edges. A verdict is faulty if the first sample is wrong or the two
// samples disagree. Trial/fault statistics and the first faulty value are kept.
module glitch_fault_monitor #(
  parameter int DATA_W = 4,
  parameter int SETTLE = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_in1,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W:0]   dut_out,
  input  logic              clr_counts,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [DATA_W:0]   expected,
  output logic [CNT_W-1:0]  trial_count,
  output logic [CNT_W-1:0]  fault_count,
  output logic [DATA_W:0]   first_fault_val,
  output logic              first_fault_vld
);

  localparam int SW = ($clog2(SETTLE) < 1) ? 1 : $clog2(SETTLE);
  localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE_ST,
    SAMPLE1,
    SAMPLE2,
    REPORT
  } state_t;

  state_t            state;
  logic [SW-1:0]     settle_cnt;
  logic [DATA_W-1:0] a_l;
  logic [DATA_W-1:0] b_l;
  logic [DATA_W:0]   s1;
  logic [DATA_W:0]   s2;
  logic [DATA_W:0]   exp_sum;
  logic              verdict;

  assign exp_sum = {1'b0, a_l} + {1'b0, b_l};
  assign verdict = (s1 != exp_sum) | (s1 != s2);

  // Trial sequencer: latch operands, wait out settling, double-sample, then report
  always_ff @(posedge clk_in1) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      a_l        <= '0;
      b_l        <= '0;
      s1         <= '0;
      s2         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      expected   <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_l        <= a;
            b_l        <= b;
            settle_cnt <= SETTLE_LOAD;
            busy       <= 1'b1;
            state      <= SETTLE_ST;
          end
        end
        SETTLE_ST: begin
          if (settle_cnt == '0) begin
            state <= SAMPLE1;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        SAMPLE1: begin
          s1    <= dut_out;
          state <= SAMPLE2;
        end
        SAMPLE2: begin
          s2    <= dut_out;
          state <= REPORT;
        end
        REPORT: begin
          done     <= 1'b1;
          fault    <= verdict;
          expected <= exp_sum;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Saturating statistics and first-fault capture; a clear request beats a report
  always_ff @(posedge clk_in1) begin
    if (rst || clr_counts) begin
      trial_count     <= '0;
      fault_count     <= '0;
      first_fault_val <= '0;
      first_fault_vld <= 1'b0;
    end else if (state == REPORT) begin
      if (trial_count != CNT_MAX) begin
        trial_count <= trial_count + CNT_W'(1);
      end
      if (verdict) begin
        if (fault_count != CNT_MAX) begin
          fault_count <= fault_count + CNT_W'(1);
        end
        if (!first_fault_vld) begin
          first_fault_val <= s1;
          first_fault_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_glitch_fault_monitor.sv
// tb_glitch_fault_monitor
// Directed trials with literal expectations plus a long randomized run, all checked
// every cycle against a trial-timeline model of the monitor.
module tb_glitch_fault_monitor;

  localparam int DATA_W  = 4;
  localparam int SETTLE  = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk_in1 = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] a = '0;
  logic [DATA_W-1:0] b = '0;
  logic [DATA_W:0]   dut_out = '0;
  logic              clr_counts = 1'b0;
  logic              busy;
  logic              done;
  logic              fault;
  logic [DATA_W:0]   expected;
  logic [CNT_W-1:0]  trial_count;
  logic [CNT_W-1:0]  fault_count;
  logic [DATA_W:0]   first_fault_val;
  logic              first_fault_vld;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  glitch_fault_monitor #(.DATA_W(DATA_W), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk_in1(clk_in1),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .dut_out(dut_out),
    .clr_counts(clr_counts),
    .busy(busy),
    .done(done),
    .fault(fault),
    .expected(expected),
    .trial_count(trial_count),
    .fault_count(fault_count),
    .first_fault_val(first_fault_val),
    .first_fault_vld(first_fault_vld)
  );

  always #5 clk_in1 = ~clk_in1;

  // Reference model: a trial accepted at edge t0 samples at t0+SETTLE+1 and
  // t0+SETTLE+2 and reports on edge t0+SETTLE+3
  int edge_n = 0;
  int t0 = 0;
  int m_a = 0, m_b = 0, m_s1 = 0, m_s2 = 0, m_exp = 0;
  int m_tc = 0, m_fc = 0, m_ffv = 0, golden = 0, rel = 0;
  bit in_trial = 0, m_done = 0, m_fault = 0, m_ffvld = 0, vrd = 0, rep = 0;

  always @(posedge clk_in1) begin
    edge_n = edge_n + 1;
    if (rst) begin
      in_trial = 0; m_done = 0; m_fault = 0; m_exp = 0;
      m_tc = 0; m_fc = 0; m_ffv = 0; m_ffvld = 0;
    end else begin
      m_done = 0;
      m_fault = 0;
      rep = 0;
      if (in_trial) begin
        rel = edge_n - t0;
        if (rel == SETTLE + 1) m_s1 = int'(dut_out);
        if (rel == SETTLE + 2) m_s2 = int'(dut_out);
        if (rel == SETTLE + 3) begin
          rep = 1;
          in_trial = 0;
        end
      end else if (start) begin
        in_trial = 1;
        t0 = edge_n;
        m_a = int'(a);
        m_b = int'(b);
      end
      if (rep) begin
        golden = m_a + m_b;
        vrd = (m_s1 != golden) || (m_s1 != m_s2);
        m_done = 1;
        m_fault = vrd;
        m_exp = golden;
        if (!clr_counts) begin
          if (m_tc < CNT_MAX) m_tc = m_tc + 1;
          if (vrd && m_fc < CNT_MAX) m_fc = m_fc + 1;
          if (vrd && !m_ffvld) begin
            m_ffv = m_s1;
            m_ffvld = 1;
          end
        end
      end
      if (clr_counts) begin
        m_tc = 0; m_fc = 0; m_ffv = 0; m_ffvld = 0;
      end
    end
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0d want %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk_in1) begin
    if (chk_en) begin
      checkOutput("m_busy", busy, in_trial);
      checkOutput("m_done", done, m_done);
      checkOutput("m_fault", fault, m_fault);
      checkOutput("m_expected", expected, m_exp);
      checkOutput("m_trial_count", trial_count, m_tc);
      checkOutput("m_fault_count", fault_count, m_fc);
      checkOutput("m_first_fault_val", first_fault_val, m_ffv);
      checkOutput("m_first_fault_vld", first_fault_vld, m_ffvld);
    end
  end

  task automatic applyStimulus(input logic r, input logic s, input logic [DATA_W-1:0] av,
                               input logic [DATA_W-1:0] bv, input logic [DATA_W:0] dv,
                               input logic c);
    rst = r;
    start = s;
    a = av;
    b = bv;
    dut_out = dv;
    clr_counts = c;
    @(negedge clk_in1);
  endtask

  // One trial; k counts edges after the accepting edge, extra pokes keyed on k
  task automatic run_trial(input int av, input int bv, input int dv, input int flip_k,
                           input int flip_v, input int s_k1, input int s_k2, input int clr_k,
                           output int lat);
    int n;
    int k;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk_in1);
      n++;
    end
    if (n >= 50) checkOutput("idle_wait", busy, 0);
    rst = 0;
    start = 1;
    a = DATA_W'(av);
    b = DATA_W'(bv);
    dut_out = (DATA_W+1)'(dv);
    clr_counts = 0;
    @(negedge clk_in1);
    start = 0;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk_in1);
      k++;
      start = (k == s_k1) || (k == s_k2);
      clr_counts = (k == clr_k);
      if (k == flip_k) dut_out = (DATA_W+1)'(flip_v);
    end
    start = 0;
    clr_counts = 0;
    lat = k;
    checkOutput("latency", lat, SETTLE + 3);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_in1);
      if (done) cnt++;
    end
  endtask

  int lat;
  int nd;

  initial begin
    $display("[TB] start");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    chk_en = 1;
    applyStimulus(0, 0, 0, 0, 0, 0);

    // reset state
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_expected", expected, 0);
    checkOutput("rst_trial_count", trial_count, 0);
    checkOutput("rst_ffvld", first_fault_vld, 0);

    // T1 clean trial
    run_trial(3, 4, 7, -1, 0, -1, -1, -1, lat);
    checkOutput("t1_fault", fault, 0);
    checkOutput("t1_expected", expected, 7);
    checkOutput("t1_trial_count", trial_count, 1);
    checkOutput("t1_fault_count", fault_count, 0);

    // T2 wrong value, then a second faulty trial keeps the first capture
    run_trial(15, 15, 29, -1, 0, -1, -1, -1, lat);
    checkOutput("t2_fault", fault, 1);
    checkOutput("t2_expected", expected, 30);
    checkOutput("t2_fault_count", fault_count, 1);
    checkOutput("t2_ffv", first_fault_val, 29);
    checkOutput("t2_ffvld", first_fault_vld, 1);
    run_trial(15, 15, 5, -1, 0, -1, -1, -1, lat);
    checkOutput("t2b_fault", fault, 1);
    checkOutput("t2b_ffv", first_fault_val, 29);
    checkOutput("t2b_fault_count", fault_count, 2);
    checkOutput("t2b_trial_count", trial_count, 3);

    // T3 unstable output: correct in the first sample, different in the second
    run_trial(1, 1, 2, SETTLE + 1, 3, -1, -1, -1, lat);
    checkOutput("t3_fault", fault, 1);
    checkOutput("t3_expected", expected, 2);

    // T4 start during SETTLE and REPORT is ignored
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t4_cleared", trial_count, 0);
    run_trial(3, 3, 6, -1, 0, 3, SETTLE + 2, -1, lat);
    checkOutput("t4_trial_count", trial_count, 1);
    count_dones(20, nd);
    checkOutput("t4_extra_done", nd, 0);
    checkOutput("t4_busy", busy, 0);

    // T5 reset in the middle of settling
    applyStimulus(0, 1, 2, 3, 5, 0);
    start = 0;
    repeat (3) @(negedge clk_in1);
    rst = 1;
    @(negedge clk_in1);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_trial_count", trial_count, 0);
    rst = 0;
    count_dones(20, nd);
    checkOutput("t5_no_done", nd, 0);
    run_trial(5, 6, 11, -1, 0, -1, -1, -1, lat);
    checkOutput("t5_fault", fault, 0);
    checkOutput("t5_expected", expected, 11);
    checkOutput("t5_trial_count_after", trial_count, 1);

    // T6 clear in the REPORT cycle of a faulty trial wins over the update
    run_trial(1, 2, 0, -1, 0, -1, -1, SETTLE + 2, lat);
    checkOutput("t6_fault", fault, 1);
    checkOutput("t6_trial_count", trial_count, 0);
    checkOutput("t6_fault_count", fault_count, 0);
    checkOutput("t6_ffvld", first_fault_vld, 0);

    // Saturation of trial_count
    for (int i = 0; i < CNT_MAX + 2; i++) run_trial(1, 1, 2, -1, 0, -1, -1, -1, lat);
    checkOutput("sat_trial_count", trial_count, CNT_MAX);

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      logic [DATA_W:0] dv;
      dv = (($urandom % 4) == 0) ? (DATA_W+1)'($urandom) : (DATA_W+1)'(m_a + m_b);
      applyStimulus(($urandom % 150) == 0, ($urandom % 3) == 0, DATA_W'($urandom),
                    DATA_W'($urandom), dv, ($urandom % 80) == 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (SETTLE + 6) @(negedge clk_in1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
